ball_engine: RTL and testbench
==============================

# ball_engine

Ball physics and scoring for the Pong playfield. Consumes the upper and lower paddle centre positions produced by the paddle controller, advances the ball on a fixed frame tick, bounces it off side walls and paddles, and detects misses. Drives ball coordinates and scores to the renderer and the score display.

## Interface
- FIELD_W, 240: playfield width in pixels (x axis, paddle travel axis)
- FIELD_H, 320: playfield height in pixels (y axis; upper paddle at y=0, lower paddle at y=FIELD_H-1)
- PADDLE_LENGTH, 40: paddle extent along x
- PADDLE_WIDTH, 4: paddle thickness along y
- BALL_SIZE, 4: ball square side
- TICK_DIV, 416667: clock cycles per movement tick
- SERVE_TICKS, 60: ticks of pause before a serve launches
- WIN_SCORE, 9: score that ends the game
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- paddleU_pos  in  9  upper paddle centre x
- paddleD_pos  in  9  lower paddle centre x
- serve  in  1  level; starts play from IDLE or GAMEOVER
- ball_x  out  9  ball top-left x
- ball_y  out  9  ball top-left y
- scoreU  out  4  upper player score
- scoreD  out  4  lower player score
- point_scored  out  1  one-cycle pulse per point
- game_over  out  1  high in GAMEOVER

## Operation
- States: IDLE, SERVE, PLAY, SCORED, GAMEOVER.
- IDLE: ball centred (x=(FIELD_W-BALL_SIZE)/2=118, y=(FIELD_H-BALL_SIZE)/2=158); serve=1 -> SERVE.
- SERVE: ball centred, speed=1, hit counter=0; counts SERVE_TICKS ticks then -> PLAY.
- PLAY: on each tick, x += dx (±1), y += dy*speed (speed 1..3).
- Side walls: x_next computed 10-bit signed; x_next<=0 -> x=0, dx=+1; x_next>=FIELD_W-BALL_SIZE -> x=FIELD_W-BALL_SIZE, dx=-1.
- Paddle span: left=pos-(PADDLE_LENGTH/2-1), right=pos+PADDLE_LENGTH/2, 10-bit signed, no clamping. Overlap when ball_x+BALL_SIZE-1>=left and ball_x<=right.
- Moving up, y_next<=PADDLE_WIDTH: overlap with upper paddle -> y=PADDLE_WIDTH, dy=+1, hits++; else y=0, lower player scores -> SCORED.
- Moving down, y_next>=FIELD_H-PADDLE_WIDTH-BALL_SIZE (=312): overlap with lower paddle -> y=312, dy=-1, hits++; else y=FIELD_H-BALL_SIZE, upper player scores -> SCORED.
- Every 4th hit, speed increments, saturating at 3.
- Wall and paddle bounce in the same tick (corner): both applied.
- SCORED (1 cycle): increment scorer, point_scored=1; scorer reaching WIN_SCORE -> GAMEOVER, else -> SERVE. Next serve dy points toward the player who conceded; dx toggles each serve.
- GAMEOVER: ball frozen, game_over=1; serve=1 clears scores -> SERVE.
- Paddle positions sampled only at tick evaluation.

## Timing
- Reset values: ball centred (118,158), scores 0, point_scored 0, game_over 0, state IDLE, dx=+1, dy=+1, speed 1, tick counter 0.
- Tick: divider counts 0..TICK_DIV-1, tick high the cycle count==TICK_DIV-1.
- Outputs registered; ball moves the cycle after tick.
- serve sampled every cycle in IDLE/GAMEOVER; transition next cycle.
- SERVE -> PLAY on the SERVE_TICKS-th tick; first motion on the following tick.
- point_scored high exactly one cycle, concurrent with score update.
- Reset mid-game returns to IDLE next cycle, discarding scores.

## Structure
- pong_pkg: FIELD_W/FIELD_H, paddle geometry constants, state enum, signed 10-bit coordinate type (shared with paddle controller and renderer).
- Sub-module: tick_gen (TICK_DIV counter, reset-clearable).

## Test plan
- Reset, no serve, TICK_DIV=2 -> ball (118,158), IDLE, scores 0 indefinitely.
- serve, SERVE_TICKS=2, dx=+1, dy=+1 -> PLAY after 2 ticks; ball then (119,159),(120,160).
- Ball at x=236 moving right -> x clamps 236, dx=-1, next tick x=235.
- Ball descending to y=312, paddleD_pos=120 overlapping -> y=312, dy=-1, hits=1; 4 hits -> speed 2.
- Ball descending, paddleD_pos=20, ball_x=200 -> y=316, scoreU=1, point_scored one cycle, SERVE with dy=+1.
- scoreU=8, another upper point -> scoreU=9, GAMEOVER, game_over=1; serve -> scores 0, SERVE.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - Pong playfield geometry, game states and shared coordinate type.
package pong_pkg;

  localparam int FIELD_W       = 240;
  localparam int FIELD_H       = 320;
  localparam int PADDLE_LENGTH = 40;
  localparam int PADDLE_WIDTH  = 4;
  localparam int BALL_SIZE     = 4;

  localparam int X_MAX     = FIELD_W - BALL_SIZE;
  localparam int Y_MAX     = FIELD_H - BALL_SIZE;
  localparam int Y_LOWER   = FIELD_H - PADDLE_WIDTH - BALL_SIZE;
  localparam int X_CENTRE  = (FIELD_W - BALL_SIZE) / 2;
  localparam int Y_CENTRE  = (FIELD_H - BALL_SIZE) / 2;

  typedef logic signed [9:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_SCORED   = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_t;

  // Paddle span is deliberately unclamped so paddles near a wall still cover the corner.
  function automatic logic paddle_overlap(input logic [8:0] bx, input logic [8:0] pos);
    coord_t b;
    coord_t left;
    coord_t right;
    b     = coord_t'({1'b0, bx});
    left  = coord_t'({1'b0, pos}) - coord_t'(PADDLE_LENGTH / 2 - 1);
    right = coord_t'({1'b0, pos}) + coord_t'(PADDLE_LENGTH / 2);
    return (b + coord_t'(BALL_SIZE - 1) >= left) && (b <= right);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - Frame tick divider: one-cycle tick every TICK_DIV clocks.
module tick_gen #(
  parameter int TICK_DIV = 416667
) (
  input  logic clock,
  input  logic reset,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count_q;

  assign tick_o = (count_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset || tick_o) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/ball_engine.sv
// rtl/ball_engine.sv - Pong ball physics, paddle/wall bounces, scoring and game FSM.
module ball_engine
  import pong_pkg::*;
#(
  parameter int TICK_DIV    = 416667,
  parameter int SERVE_TICKS = 60,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] paddleU_pos,
  input  logic [8:0] paddleD_pos,
  input  logic       serve,
  output logic [8:0] ball_x,
  output logic [8:0] ball_y,
  output logic [3:0] scoreU,
  output logic [3:0] scoreD,
  output logic       point_scored,
  output logic       game_over
);

  localparam int SCW = $clog2(SERVE_TICKS + 1);

  logic tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clock  (clock),
    .reset  (reset),
    .tick_o (tick)
  );

  state_t         state_q, state_d;
  logic [8:0]     x_q, x_d, y_q, y_d;
  logic           dx_pos_q, dx_pos_d;
  logic           dy_down_q, dy_down_d;
  logic           serve_dx_q, serve_dx_d;
  logic [1:0]     speed_q, speed_d;
  logic [1:0]     hits_q, hits_d;
  logic [SCW-1:0] serve_cnt_q, serve_cnt_d;
  logic [3:0]     score_up_q, score_up_d;
  logic [3:0]     score_lo_q, score_lo_d;
  logic           point_q, point_d;

  coord_t x_step, y_step, speed_c;
  logic   hit, begin_serve;

  always_comb begin
    speed_c = coord_t'({8'd0, speed_q});
    x_step  = dx_pos_q  ? coord_t'({1'b0, x_q}) + 10'sd1 : coord_t'({1'b0, x_q}) - 10'sd1;
    y_step  = dy_down_q ? coord_t'({1'b0, y_q}) + speed_c : coord_t'({1'b0, y_q}) - speed_c;
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_pos_d    = dx_pos_q;
    dy_down_d   = dy_down_q;
    serve_dx_d  = serve_dx_q;
    speed_d     = speed_q;
    hits_d      = hits_q;
    serve_cnt_d = serve_cnt_q;
    score_up_d  = score_up_q;
    score_lo_d  = score_lo_q;
    point_d     = 1'b0;
    hit         = 1'b0;
    begin_serve = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (serve) begin
          begin_serve = 1'b1;
        end
      end
      ST_SERVE: begin
        if (tick) begin
          if (serve_cnt_q == SCW'(SERVE_TICKS - 1)) begin
            state_d     = ST_PLAY;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (tick) begin
          if (x_step <= 10'sd0) begin
            x_d      = 9'd0;
            dx_pos_d = 1'b1;
          end else if (x_step >= coord_t'(X_MAX)) begin
            x_d      = 9'(X_MAX);
            dx_pos_d = 1'b0;
          end else begin
            x_d = x_step[8:0];
          end
          y_d = y_step[8:0];
          // Overlap uses the pre-move x; a miss leaves dy pointing at the conceder for the next serve.
          if (!dy_down_q && (y_step <= coord_t'(PADDLE_WIDTH))) begin
            if (paddle_overlap(x_q, paddleU_pos)) begin
              y_d       = 9'(PADDLE_WIDTH);
              dy_down_d = 1'b1;
              hit       = 1'b1;
            end else begin
              y_d        = 9'd0;
              score_lo_d = score_lo_q + 4'd1;
              point_d    = 1'b1;
              state_d    = ST_SCORED;
            end
          end else if (dy_down_q && (y_step >= coord_t'(Y_LOWER))) begin
            if (paddle_overlap(x_q, paddleD_pos)) begin
              y_d       = 9'(Y_LOWER);
              dy_down_d = 1'b0;
              hit       = 1'b1;
            end else begin
              y_d        = 9'(Y_MAX);
              score_up_d = score_up_q + 4'd1;
              point_d    = 1'b1;
              state_d    = ST_SCORED;
            end
          end
        end
      end
      ST_SCORED: begin
        serve_dx_d = ~serve_dx_q;
        dx_pos_d   = ~serve_dx_q;
        if (score_up_q == 4'(WIN_SCORE) || score_lo_q == 4'(WIN_SCORE)) begin
          state_d = ST_GAMEOVER;
        end else begin
          begin_serve = 1'b1;
        end
      end
      ST_GAMEOVER: begin
        if (serve) begin
          score_up_d  = 4'd0;
          score_lo_d  = 4'd0;
          begin_serve = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (begin_serve) begin
      state_d     = ST_SERVE;
      x_d         = 9'(X_CENTRE);
      y_d         = 9'(Y_CENTRE);
      speed_d     = 2'd1;
      hits_d      = 2'd0;
      serve_cnt_d = '0;
    end

    if (hit) begin
      hits_d = hits_q + 2'd1;
      if (hits_q == 2'd3 && speed_q != 2'd3) begin
        speed_d = speed_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x_q         <= 9'(X_CENTRE);
      y_q         <= 9'(Y_CENTRE);
      dx_pos_q    <= 1'b1;
      dy_down_q   <= 1'b1;
      serve_dx_q  <= 1'b1;
      speed_q     <= 2'd1;
      hits_q      <= 2'd0;
      serve_cnt_q <= '0;
      score_up_q  <= 4'd0;
      score_lo_q  <= 4'd0;
      point_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_pos_q    <= dx_pos_d;
      dy_down_q   <= dy_down_d;
      serve_dx_q  <= serve_dx_d;
      speed_q     <= speed_d;
      hits_q      <= hits_d;
      serve_cnt_q <= serve_cnt_d;
      score_up_q  <= score_up_d;
      score_lo_q  <= score_lo_d;
      point_q     <= point_d;
    end
  end

  assign ball_x       = x_q;
  assign ball_y       = y_q;
  assign scoreU       = score_up_q;
  assign scoreD       = score_lo_q;
  assign point_scored = point_q;
  assign game_over    = (state_q == ST_GAMEOVER);

endmodule

// File: tb/tb_ball_engine.sv
// tb/tb_ball_engine.sv - Self-checking bench for ball_engine against a behavioural game model.
module tb_ball_engine;

  localparam int TD = 2;
  localparam int ST = 2;
  localparam int WS = 9;

  localparam int M_IDLE  = 0;
  localparam int M_SERVE = 1;
  localparam int M_PLAY  = 2;
  localparam int M_SCORE = 3;
  localparam int M_OVER  = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       serve = 1'b0;
  logic [8:0] pu = 9'd120;
  logic [8:0] pd = 9'd120;
  logic [8:0] ball_x, ball_y;
  logic [3:0] scoreU, scoreD;
  logic       point_scored, game_over;

  ball_engine #(.TICK_DIV(TD), .SERVE_TICKS(ST), .WIN_SCORE(WS)) dut (
    .clock        (clock),
    .reset        (reset),
    .paddleU_pos  (pu),
    .paddleD_pos  (pd),
    .serve        (serve),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .scoreU       (scoreU),
    .scoreD       (scoreD),
    .point_scored (point_scored),
    .game_over    (game_over)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int ms = M_IDLE, mx = 118, my = 158, mdx = 1, mdy = 1;
  int mhits = 0, mtc = 0, mst = 0, msu = 0, msd = 0, mpoint = 0, mpoints_served = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit covers(input int bx, input int pos);
    return (bx + 3 >= pos - 19) && (bx <= pos + 20);
  endfunction

  task automatic start_serve();
    ms = M_SERVE; mx = 118; my = 158; mhits = 0; mst = 0;
  endtask

  task automatic model_step();
    int nx, ny, spd, oldx;
    bit tk;
    if (reset) begin
      ms = M_IDLE; mx = 118; my = 158; mdx = 1; mdy = 1; mhits = 0;
      mtc = 0; mst = 0; msu = 0; msd = 0; mpoint = 0; mpoints_served = 0;
      return;
    end
    tk = (mtc == TD - 1);
    mtc = tk ? 0 : mtc + 1;
    mpoint = 0;
    case (ms)
      M_IDLE: if (serve) start_serve();
      M_SERVE: if (tk) begin
        mst++;
        if (mst == ST) ms = M_PLAY;
      end
      M_PLAY: if (tk) begin
        spd = (mhits / 4 + 1 > 3) ? 3 : mhits / 4 + 1;
        oldx = mx;
        nx = mx + mdx;
        ny = my + mdy * spd;
        if (nx <= 0) begin mx = 0; mdx = 1; end
        else if (nx >= 236) begin mx = 236; mdx = -1; end
        else mx = nx;
        my = ny;
        if (mdy < 0 && ny <= 4) begin
          if (covers(oldx, int'(pu))) begin my = 4; mdy = 1; mhits++; end
          else begin my = 0; msd++; mpoint = 1; mdy = -1; ms = M_SCORE; end
        end else if (mdy > 0 && ny >= 312) begin
          if (covers(oldx, int'(pd))) begin my = 312; mdy = -1; mhits++; end
          else begin my = 316; msu++; mpoint = 1; mdy = 1; ms = M_SCORE; end
        end
      end
      M_SCORE: begin
        mpoints_served++;
        mdx = (mpoints_served % 2 == 1) ? -1 : 1;
        if (msu == WS || msd == WS) ms = M_OVER;
        else start_serve();
      end
      M_OVER: if (serve) begin msu = 0; msd = 0; start_serve(); end
      default: ms = M_IDLE;
    endcase
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  function automatic logic [8:0] aim(input int bx);
    int t;
    if ($urandom % 6 == 0) return 9'($urandom_range(0, 239));
    t = bx + int'($urandom_range(0, 80)) - 40;
    if (t < 0) t = 0;
    if (t > 239) t = 239;
    return 9'(t);
  endfunction

  task automatic drive_random();
    pu = aim(mx);
    pd = aim(mx);
    serve = ($urandom % 16 == 0);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("ball_x", int'(ball_x), mx);
      check("ball_y", int'(ball_y), my);
      check("scoreU", int'(scoreU), msu);
      check("scoreD", int'(scoreD), msd);
      check("point_scored", int'(point_scored), mpoint);
      check("game_over", int'(game_over), (ms == M_OVER) ? 1 : 0);
    end
  end

  initial begin
    int m, games;
    logic [8:0] px, py;
    bit prev_go;

    repeat (3) cycle();
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset_x", int'(ball_x), 118);
    check("reset_y", int'(ball_y), 158);
    check("reset_scoreU", int'(scoreU), 0);
    check("reset_game_over", int'(game_over), 0);
    repeat (20) cycle();
    check("idle_x", int'(ball_x), 118);
    check("idle_y", int'(ball_y), 158);
    check("idle_scoreD", int'(scoreD), 0);

    // Both paddles parked far left so the first descent misses at x=200.
    pu = 9'd20;
    pd = 9'd20;
    serve = 1'b1;
    cycle();
    serve = 1'b0;
    px = ball_x;
    py = ball_y;
    m = 0;
    for (int c = 0; c < 2000 && m < 156; c++) begin
      cycle();
      if (ball_x != px || ball_y != py) begin
        m++;
        px = ball_x;
        py = ball_y;
        case (m)
          1: begin check("m1_x", int'(ball_x), 119); check("m1_y", int'(ball_y), 159); end
          2: begin check("m2_x", int'(ball_x), 120); check("m2_y", int'(ball_y), 160); end
          118: check("wall_clamp_x", int'(ball_x), 236);
          119: check("wall_rebound_x", int'(ball_x), 235);
          154: begin
            check("miss_x", int'(ball_x), 200);
            check("miss_y", int'(ball_y), 316);
            check("miss_scoreU", int'(scoreU), 1);
            check("miss_point", int'(point_scored), 1);
          end
          155: begin
            check("reserve_x", int'(ball_x), 118);
            check("reserve_y", int'(ball_y), 158);
            check("reserve_point", int'(point_scored), 0);
          end
          156: begin check("serve2_x", int'(ball_x), 117); check("serve2_y", int'(ball_y), 159); end
          default: ;
        endcase
      end
    end
    check("directed_motions", m, 156);

    games = 0;
    prev_go = 1'b0;
    for (int c = 0; c < 60000 && games < 1; c++) begin
      drive_random();
      cycle();
      if (game_over && !prev_go) begin
        games++;
        check("win_score", (scoreU > scoreD) ? int'(scoreU) : int'(scoreD), 9);
      end
      prev_go = game_over;
    end
    check("game_finished", games, 1);

    serve = 1'b1;
    cycle();
    serve = 1'b0;
    check("restart_scoreU", int'(scoreU), 0);
    check("restart_scoreD", int'(scoreD), 0);
    check("restart_game_over", int'(game_over), 0);

    repeat (3000) begin drive_random(); cycle(); end
    reset = 1'b1;
    serve = 1'b0;
    cycle();
    reset = 1'b0;
    check("midreset_x", int'(ball_x), 118);
    check("midreset_y", int'(ball_y), 158);
    check("midreset_scores", int'(scoreU) + int'(scoreD), 0);
    check("midreset_game_over", int'(game_over), 0);
    repeat (2000) begin drive_random(); cycle(); end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
